// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler
// Round-robin issue arbiter for N issue queues feeding N execution units that
// share a single common data bus. A shift-register reservation table books
// the CDB cycle of every issued instruction so that no two results ever
// collide. Non-pipelined units are held off until their previous result
// reaches the CDB.
`timescale 1ns/1ps
module cdb_issue_scheduler #(
  parameter int                         NUM_UNITS = 4,
  parameter int                         LAT_W     = 3,
  parameter int                         MAX_LAT   = 6,
  parameter logic [NUM_UNITS*LAT_W-1:0] UNIT_LAT  = 12'h5A1,
  parameter logic [NUM_UNITS-1:0]       PIPELINED = 4'b1011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] ready,
  input  logic [NUM_UNITS-1:0] unit_busy,
  output logic [NUM_UNITS-1:0] issue,
  output logic                 cdb_valid,
  output logic [NUM_UNITS-1:0] cdb_sel
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Reservation table: slot k booked means the CDB is used k cycles from now.
  logic [MAX_LAT-1:0] rsv_vld;
  logic [PTR_W-1:0]   rsv_idx [MAX_LAT];
  logic [MAX_LAT-1:0] rsv_set;

  logic [PTR_W-1:0]   rr_ptr;
  logic [LAT_W-1:0]   busy_cnt [NUM_UNITS];
  logic [LAT_W-1:0]   lat_m1   [NUM_UNITS];

  logic [NUM_UNITS-1:0] slot_free;
  logic [NUM_UNITS-1:0] unit_idle;
  logic [NUM_UNITS-1:0] elig;
  logic [NUM_UNITS-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;
  logic                 grant_vld;

  // Per-unit constants and eligibility. A unit of latency L lands in slot
  // L-1 after this cycle's shift, so it needs slot L free right now; a
  // latency of MAX_LAT always targets the freshly emptied top slot.
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    localparam int LAT = int'(UNIT_LAT[g*LAT_W +: LAT_W]);

    if (LAT < 1 || LAT > MAX_LAT) begin : g_bad_lat
      $error("cdb_issue_scheduler: unit %0d latency %0d outside 1..%0d", g, LAT, MAX_LAT);
    end

    assign lat_m1[g] = LAT_W'(LAT - 1);

    if (LAT >= MAX_LAT) begin : g_top_slot
      assign slot_free[g] = 1'b1;
    end else begin : g_mid_slot
      assign slot_free[g] = ~rsv_vld[LAT];
    end

    if (PIPELINED[g]) begin : g_pipe
      assign unit_idle[g] = 1'b1;
    end else begin : g_nonpipe
      assign unit_idle[g] = (busy_cnt[g] == '0);
    end

    assign elig[g] = ready[g] & ~unit_busy[g] & slot_free[g] & unit_idle[g];
  end

  // Round-robin pick: first eligible unit at or after rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_UNITS);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = grant_vld;
  end

  // The grant doubles as the queue's dequeue strobe, so it must be silent in reset.
  assign issue = rst ? '0 : grant;

  // Decode which reservation slot the granted unit books.
  always_comb begin
    rsv_set = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      rsv_set[k] = grant_vld && (lat_m1[grant_idx] == LAT_W'(k));
    end
  end

  // Control state: reservation valids, round-robin pointer, busy counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_vld <= '0;
      rr_ptr  <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        busy_cnt[u] <= '0;
      end
    end else begin
      rsv_vld <= (rsv_vld >> 1) | rsv_set;
      if (grant_vld) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (grant[u] && !PIPELINED[u]) begin
          busy_cnt[u] <= lat_m1[u];
        end else if (busy_cnt[u] != '0) begin
          busy_cnt[u] <= busy_cnt[u] - 1'b1;
        end
      end
    end
  end

  // Unit indices ride along with the valids; meaningless where the valid is clear.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      rsv_idx[k] <= rsv_set[k] ? grant_idx : rsv_idx[k+1];
    end
    rsv_idx[MAX_LAT-1] <= grant_idx;
  end

  // CDB mux select straight from the head of the table.
  always_comb begin
    cdb_sel = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      cdb_sel[u] = rsv_vld[0] && (rsv_idx[0] == PTR_W'(u));
    end
  end

  assign cdb_valid = rsv_vld[0];

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Scoreboard bench for cdb_issue_scheduler with default parameters.
// Directed scenarios push the hand-derived issue and CDB events (absolute
// cycle plus one-hot value) into queues; a negedge monitor pops and compares
// whenever the DUT shows an issue or a CDB result.
`timescale 1ns/1ps
module tb_cdb_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ready = 4'b0;
  logic [3:0] unit_busy = 4'b0;
  logic [3:0] issue;
  logic       cdb_valid;
  logic [3:0] cdb_sel;

  cdb_issue_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .unit_busy (unit_busy),
    .issue     (issue),
    .cdb_valid (cdb_valid),
    .cdb_sel   (cdb_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  ev_t exp_iss[$];
  ev_t exp_cdb[$];
  ev_t ev;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  int  base     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input ev_t e);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got nothing required %b at cycle %0d (now %0d)", name, e.val, e.cyc, cyc);
  endtask

  // Monitor: compare every presented issue / CDB result against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_iss.size() > 0 && exp_iss[0].cyc < cyc) miss("issue_missing", exp_iss.pop_front());
      while (exp_cdb.size() > 0 && exp_cdb[0].cyc < cyc) miss("cdb_missing", exp_cdb.pop_front());

      if (issue !== 4'b0000) begin
        if (exp_iss.size() == 0) begin
          chk("issue_unexpected", 32'(issue), 32'h0);
        end else begin
          ev = exp_iss.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(ev.cyc));
          chk("issue_value", 32'(issue), 32'(ev.val));
        end
      end

      if (cdb_valid !== 1'b0) begin
        if (exp_cdb.size() == 0) begin
          chk("cdb_unexpected", 32'(cdb_sel), 32'h0);
        end else begin
          ev = exp_cdb.pop_front();
          chk("cdb_cycle", 32'(cyc), 32'(ev.cyc));
          chk("cdb_sel", 32'(cdb_sel), 32'(ev.val));
        end
      end else begin
        chk("cdb_sel_idle", 32'(cdb_sel), 32'h0);
      end
    end
  end

  task automatic push_iss(input int t, input logic [3:0] v);
    exp_iss.push_back('{cyc: base + t, val: v});
  endtask

  task automatic push_cdb(input int t, input logic [3:0] v);
    exp_cdb.push_back('{cyc: base + t, val: v});
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic rs);
    ready     = r;
    unit_busy = b;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ready     = 4'b1111;
    unit_busy = 4'b0000;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_issue", 32'(issue), 32'h0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("rst_cdb_sel", 32'(cdb_sel), 32'h0);
    @(posedge clk);
    #1;
    ready  = 4'b0000;
    rst    = 1'b0;
    mon_en = 1'b1;
    base   = cyc;
  endtask

  task automatic end_scn();
    repeat (8) drive(4'b0000, 4'b0000, 1'b0);
    chk("pending_issue", 32'(exp_iss.size()), 32'h0);
    chk("pending_cdb", 32'(exp_cdb.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(4'b0000, 4'b0000, 1'b1);

    // Single int issue, result one cycle later.
    do_reset();
    push_iss(0, 4'b0001);
    push_cdb(1, 4'b0001);
    drive(4'b0001, 4'b0000, 1'b0);
    end_scn();

    // Slot collision: int waits one cycle behind the mult result.
    do_reset();
    push_iss(0, 4'b0010);
    push_iss(4, 4'b0001);
    push_cdb(4, 4'b0010);
    push_cdb(5, 4'b0001);
    drive(4'b0010, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0001, 4'b0000, 1'b0);
    drive(4'b0001, 4'b0000, 1'b0);
    end_scn();

    // Round-robin int/mult, with int stalling whenever its slot is booked.
    do_reset();
    push_iss(0, 4'b0001); push_iss(1, 4'b0010); push_iss(2, 4'b0001); push_iss(3, 4'b0010);
    push_iss(4, 4'b0010); push_iss(5, 4'b0001); push_iss(6, 4'b0010); push_iss(7, 4'b0010);
    push_cdb(1, 4'b0001); push_cdb(3, 4'b0001); push_cdb(5, 4'b0010); push_cdb(6, 4'b0001);
    push_cdb(7, 4'b0010); push_cdb(8, 4'b0010); push_cdb(10, 4'b0010); push_cdb(11, 4'b0010);
    repeat (8) drive(4'b0011, 4'b0000, 1'b0);
    end_scn();

    // Non-pipelined div re-issues only when its result reaches the CDB.
    do_reset();
    push_iss(0, 4'b0100); push_iss(6, 4'b0100); push_iss(12, 4'b0100);
    push_cdb(6, 4'b0100); push_cdb(12, 4'b0100); push_cdb(18, 4'b0100);
    repeat (14) drive(4'b0100, 4'b0000, 1'b0);
    end_scn();

    // External hold on mem for three cycles.
    do_reset();
    push_iss(3, 4'b1000);
    push_cdb(5, 4'b1000);
    repeat (3) drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b1000, 4'b0000, 1'b0);
    end_scn();

    // Reset mid-flight: mult reservation dropped, pointer back to unit 0.
    do_reset();
    push_iss(0, 4'b0010);
    push_iss(3, 4'b0010);
    push_cdb(7, 4'b0010);
    drive(4'b0010, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    ready = 4'b0001;
    rst   = 1'b1;
    @(negedge clk);
    chk("midflight_rst_issue", 32'(issue), 32'h0);
    @(posedge clk);
    #1;
    ready = 4'b0110;
    rst   = 1'b0;
    for (int t = 3; t <= 6; t++) begin
      @(negedge clk);
      chk("midflight_cdb_valid", 32'(cdb_valid), 32'h0);
      @(posedge clk);
      #1;
      ready = 4'b0000;
    end
    end_scn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
